// File: rtl/glb_bank_req_arbiter_pkg.sv
// Shared global-buffer parameters for the per-bank request arbiter.
// Defines requester indices, tag width and the read-tag pipeline entry.
package glb_bank_req_arbiter_pkg;

  // Fixed read latency of the bank memory wrapper, in cycles from rd_en to rdata.
  localparam int TILE2SRAM_RD_DELAY = 3;

  // Number of requesters sharing one bank port.
  localparam int GLB_NUM_REQ = 3;

  // Requester indices.
  localparam int GLB_REQ_PROC   = 0;
  localparam int GLB_REQ_LD_DMA = 1;
  localparam int GLB_REQ_ST_DMA = 2;

  // Width of a requester id carried alongside outstanding reads.
  localparam int GLB_REQ_ID_WIDTH = $clog2(GLB_NUM_REQ);

  // One stage of the read-tag pipeline: a read is in flight for requester id.
  typedef struct packed {
    logic                        valid;
    logic [GLB_REQ_ID_WIDTH-1:0] id;
  } glb_bank_tag_t;

endpackage

// File: rtl/glb_rr_arbiter.sv
// NUM_REQ-wide round-robin arbiter: combinational one-hot grant searched from
// a rotating priority pointer, pointer advanced past the winner on each grant.
// Every grant is a transfer, because a grant is only given to a valid request.
module glb_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Search requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    sum       = '0;
    idx       = '0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
          sum = sum - (ID_W+1)'(NUM_REQ);
        end
        idx = sum[ID_W-1:0];
        if (!gnt_valid && req[idx]) begin
          gnt[idx]  = 1'b1;
          gnt_valid = 1'b1;
          gnt_id    = idx;
        end
      end
    end
  end

  // Next pointer: one past the winner, otherwise unchanged.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/glb_bank_req_arbiter.sv
// Per-bank request arbiter: round-robin shares one GLB bank port between the
// processor, load DMA and store DMA, registers the winning command toward the
// bank and routes each fixed-latency read response back to its requester.
//
// Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i];
// it holds valid and payload stable until then, may drop valid ungranted with
// no effect, and must accept rsp_valid unconditionally (no response backpressure).
module glb_bank_req_arbiter
  import glb_bank_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = GLB_NUM_REQ,
  parameter int BANK_ADDR_WIDTH = 16,
  parameter int BANK_DATA_WIDTH = 64,
  parameter int BANK_STRB_WIDTH = BANK_DATA_WIDTH / 8,
  parameter int RD_LATENCY      = TILE2SRAM_RD_DELAY
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_wr,
  input  logic [NUM_REQ*BANK_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BANK_DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*BANK_STRB_WIDTH-1:0] req_strb,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               bank_wr_en,
  output logic                               bank_rd_en,
  output logic [BANK_ADDR_WIDTH-1:0]         bank_addr,
  output logic [BANK_DATA_WIDTH-1:0]         bank_wdata,
  output logic [BANK_STRB_WIDTH-1:0]         bank_strb,
  input  logic [BANK_DATA_WIDTH-1:0]         bank_rdata,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [BANK_DATA_WIDTH-1:0]         rsp_data
);

  localparam int ID_W = GLB_REQ_ID_WIDTH;

  logic            grant_en;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;

  logic                       wr_en_q, wr_en_d;
  logic                       rd_en_q, rd_en_d;
  logic [BANK_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BANK_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BANK_STRB_WIDTH-1:0] strb_q, strb_d;
  logic [ID_W-1:0]            id_q, id_d;

  glb_bank_tag_t tag_q [RD_LATENCY];
  glb_bank_tag_t tag_d [RD_LATENCY];

  // No grants while stalled, and none while reset holds the block idle.
  assign grant_en = !(stall || reset);

  glb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (reset),
    .en        (grant_en),
    .req       (req_valid),
    .gnt       (req_ready),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Next command: strobes pulse for one cycle per transfer, payload holds otherwise.
  always_comb begin
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    id_d    = id_q;
    if (gnt_valid) begin
      wr_en_d = req_wr[gnt_id];
      rd_en_d = !req_wr[gnt_id];
      addr_d  = req_addr[gnt_id*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
      wdata_d = req_wdata[gnt_id*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
      strb_d  = req_strb[gnt_id*BANK_STRB_WIDTH +: BANK_STRB_WIDTH];
      id_d    = gnt_id;
    end
  end

  // Command register toward the bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      id_q    <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      id_q    <= id_d;
    end
  end

  assign bank_wr_en = wr_en_q;
  assign bank_rd_en = rd_en_q;
  assign bank_addr  = addr_q;
  assign bank_wdata = wdata_q;
  assign bank_strb  = strb_q;

  // Tag pipeline: stage 0 captures the issuing read, later stages shift every
  // cycle regardless of stall so the last stage lines up with bank_rdata.
  always_comb begin
    for (int s = 0; s < RD_LATENCY; s++) begin
      tag_d[s] = '0;
    end
    tag_d[0].valid = rd_en_q;
    tag_d[0].id    = id_q;
    for (int s = 1; s < RD_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // Tag pipeline registers; reset drops every in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  // Response steering: data passes straight through while a response is due,
  // and reads as zero otherwise so idle/reset outputs stay at 0.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tag_q[RD_LATENCY-1].valid) begin
      rsp_valid[tag_q[RD_LATENCY-1].id] = 1'b1;
      rsp_data                          = bank_rdata;
    end
  end

endmodule

// File: tb/tb_glb_bank_req_arbiter.sv
// Directed bench for glb_bank_req_arbiter with a small bank memory model.
module tb_glb_bank_req_arbiter;

  localparam int NR  = 3;
  localparam int AW  = 16;
  localparam int DW  = 64;
  localparam int SW  = 8;
  localparam int RDL = 3;

  // Clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              stall;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_wr;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_strb;
  logic [NR-1:0]     req_ready;
  logic              bank_wr_en;
  logic              bank_rd_en;
  logic [AW-1:0]     bank_addr;
  logic [DW-1:0]     bank_wdata;
  logic [SW-1:0]     bank_strb;
  logic [DW-1:0]     bank_rdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;

  glb_bank_req_arbiter #(
    .NUM_REQ         (NR),
    .BANK_ADDR_WIDTH (AW),
    .BANK_DATA_WIDTH (DW),
    .BANK_STRB_WIDTH (SW),
    .RD_LATENCY      (RDL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .req_ready  (req_ready),
    .bank_wr_en (bank_wr_en),
    .bank_rd_en (bank_rd_en),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_strb  (bank_strb),
    .bank_rdata (bank_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data)
  );

  // Bank memory model: 256 words, fixed read latency RDL, reinitialised on reset.
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] rd_pipe [RDL];
  assign bank_rdata = rd_pipe[RDL-1];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= {32'h0123_4567, 24'h0, 8'(i)};
      for (int j = 0; j < RDL; j++) rd_pipe[j] <= '0;
    end else begin
      if (bank_wr_en) begin
        for (int b = 0; b < SW; b++) begin
          if (bank_strb[b]) mem[bank_addr[10:3]][8*b +: 8] <= bank_wdata[8*b +: 8];
        end
      end
      rd_pipe[0] <= bank_rd_en ? mem[bank_addr[10:3]] : '0;
      for (int j = 1; j < RDL; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
  end

  // Scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_wr[i]              = wr;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_strb[i*SW +: SW]   = s;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready),  64'(3'b000));
    chk({tag, "_wr"},    64'(bank_wr_en), 64'(1'b0));
    chk({tag, "_rd"},    64'(bank_rd_en), 64'(1'b0));
    chk({tag, "_addr"},  64'(bank_addr),  64'(16'h0));
    chk({tag, "_wdata"}, bank_wdata,      64'h0);
    chk({tag, "_strb"},  64'(bank_strb),  64'(8'h0));
    chk({tag, "_rspv"},  64'(rsp_valid),  64'(3'b000));
    chk({tag, "_rspd"},  rsp_data,        64'h0);
  endtask

  logic [NR-1:0] exp_gnt  [6];
  logic [AW-1:0] exp_addr [6];

  initial begin
    stall     = 1'b0;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;

    // Reset state, with requests pending to show no grant leaks through reset
    step(); step();
    req_valid = 3'b111;
    #1;
    chk_idle_outputs("reset");
    req_valid = '0;
    reset     = 1'b0;
    step();

    // Single read by load DMA at 0x0040 (word index 8)
    set_req(1, 1'b0, 16'h0040, 64'h0, 8'h00);
    req_valid = 3'b010;
    #1 chk("rd1_ready", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = '0;
    chk("rd1_rden", 64'(bank_rd_en), 64'(1'b1));
    chk("rd1_wren", 64'(bank_wr_en), 64'(1'b0));
    chk("rd1_addr", 64'(bank_addr),  64'(16'h0040));
    step();
    chk("rd1_rsp_c2", 64'(rsp_valid), 64'(3'b000));
    step();
    chk("rd1_rsp_c3", 64'(rsp_valid), 64'(3'b000));
    step();
    chk("rd1_rsp_c4", 64'(rsp_valid), 64'(3'b010));
    chk("rd1_data",   rsp_data,       64'h0123_4567_0000_0008);
    step();
    chk("rd1_rsp_c5", 64'(rsp_valid), 64'(3'b000));

    // All three writing continuously from pointer 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 1'b1, 16'h0200, 64'hA0, 8'hFF);
    set_req(1, 1'b1, 16'h0208, 64'hA1, 8'hFF);
    set_req(2, 1'b1, 16'h0210, 64'hA2, 8'hFF);
    exp_gnt  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_addr = '{16'h0200, 16'h0208, 16'h0210, 16'h0200, 16'h0208, 16'h0210};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_gnt", 64'(req_ready), 64'(exp_gnt[k]));
      if (k > 0) begin
        chk("rr_wren", 64'(bank_wr_en), 64'(1'b1));
        chk("rr_addr", 64'(bank_addr),  64'(exp_addr[k-1]));
      end
      step();
    end
    req_valid = '0;
    chk("rr_last_addr", 64'(bank_addr), 64'(16'h0210));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_no_rsp", 64'(rsp_valid), 64'(3'b000));
    end

    // Processor writes 0x0100, load DMA reads it back
    set_req(0, 1'b1, 16'h0100, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    req_valid = 3'b001;
    #1 chk("wr_ready", 64'(req_ready), 64'(3'b001));
    step();
    req_valid = '0;
    chk("wr_wren",  64'(bank_wr_en), 64'(1'b1));
    chk("wr_rden",  64'(bank_rd_en), 64'(1'b0));
    chk("wr_addr",  64'(bank_addr),  64'(16'h0100));
    chk("wr_wdata", bank_wdata,      64'hDEAD_BEEF_CAFE_F00D);
    chk("wr_strb",  64'(bank_strb),  64'(8'hFF));
    set_req(1, 1'b0, 16'h0100, 64'h0, 8'h00);
    req_valid = 3'b010;
    #1 chk("wrrd_ready", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = '0;
    chk("wrrd_rden", 64'(bank_rd_en), 64'(1'b1));
    chk("wrrd_norsp", 64'(rsp_valid), 64'(3'b000));
    step(); step();
    chk("wrrd_rsp_c3", 64'(rsp_valid), 64'(3'b000));
    step();
    chk("wrrd_rsp", 64'(rsp_valid), 64'(3'b010));
    chk("wrrd_data", rsp_data, 64'hDEAD_BEEF_CAFE_F00D);

    // Partial strobe merge at 0x0180, read back by store DMA
    set_req(0, 1'b1, 16'h0180, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    req_valid = 3'b001;
    #1 chk("ps_full_ready", 64'(req_ready), 64'(3'b001));
    step();
    req_valid = '0;
    set_req(0, 1'b1, 16'h0180, 64'h1111_2222_3333_4444, 8'h0F);
    req_valid = 3'b001;
    #1 chk("ps_part_ready", 64'(req_ready), 64'(3'b001));
    step();
    req_valid = '0;
    chk("ps_strb",  64'(bank_strb), 64'(8'h0F));
    chk("ps_wdata", bank_wdata,     64'h1111_2222_3333_4444);
    set_req(2, 1'b0, 16'h0180, 64'h0, 8'h00);
    req_valid = 3'b100;
    #1 chk("ps_rd_ready", 64'(req_ready), 64'(3'b100));
    step();
    req_valid = '0;
    step(); step(); step();
    chk("ps_rsp",  64'(rsp_valid), 64'(3'b100));
    chk("ps_data", rsp_data,       64'hFFFF_FFFF_3333_4444);

    // Stall with all requests pending; one command already registered
    set_req(0, 1'b1, 16'h0300, 64'hB0, 8'hFF);
    set_req(1, 1'b1, 16'h0308, 64'hB1, 8'hFF);
    set_req(2, 1'b1, 16'h0310, 64'hB2, 8'hFF);
    req_valid = 3'b111;
    #1 chk("st_pre_ready", 64'(req_ready), 64'(3'b001));
    step();
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("st_ready", 64'(req_ready),  64'(3'b000));
      chk("st_wren",  64'(bank_wr_en), 64'((k == 0) ? 1'b1 : 1'b0));
      chk("st_rden",  64'(bank_rd_en), 64'(1'b0));
      chk("st_addr",  64'(bank_addr),  64'(16'h0300));
      step();
    end
    stall = 1'b0;
    #1 chk("st_resume_ready", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = '0;
    chk("st_resume_wren", 64'(bank_wr_en), 64'(1'b1));
    chk("st_resume_addr", 64'(bank_addr),  64'(16'h0308));

    // Three back-to-back reads, then reset while they are in flight
    set_req(0, 1'b0, 16'h0040, 64'h0, 8'h00);
    set_req(1, 1'b0, 16'h0048, 64'h0, 8'h00);
    set_req(2, 1'b0, 16'h0050, 64'h0, 8'h00);
    req_valid = 3'b111;
    #1 chk("mr_gnt0", 64'(req_ready), 64'(3'b100));
    step();
    #1 chk("mr_gnt1", 64'(req_ready), 64'(3'b001));
    chk("mr_rden1", 64'(bank_rd_en), 64'(1'b1));
    step();
    #1 chk("mr_gnt2", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = '0;
    reset     = 1'b1;
    #1;
    chk_idle_outputs("mr_reset");
    step();
    reset = 1'b0;
    #1 chk("mr_rsp_after", 64'(rsp_valid), 64'(3'b000));
    for (int k = 0; k < 6; k++) begin
      step();
      chk("mr_rsp_after", 64'(rsp_valid), 64'(3'b000));
      chk("mr_rden_after", 64'(bank_rd_en), 64'(1'b0));
    end

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
